// File: rtl/gray_conv_scheduler.sv
// -----------------------------------------------------------------------------
// gray_conv_scheduler
//
// Shares one bit-serial Gray-to-binary converter between two requesters.
// A round-robin arbiter picks one request while idle. The Gray word is then
// converted MSB first, one bit per cycle. The binary word is presented to a
// single consumer, tagged with the ID of the requester that owns it.
//
// Word ports use [0:WIDTH-1] indexing, with index 0 as the MSB.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   req0_valid  requester 0 presents a Gray word
//   req0_gray   requester 0 Gray word
//   req0_ready  requester 0 word accepted this cycle (combinational)
//   req1_valid  requester 1 presents a Gray word
//   req1_gray   requester 1 Gray word
//   req1_ready  requester 1 word accepted this cycle (combinational)
//   res_valid   converted result available (registered)
//   res_ready   consumer takes the result
//   res_bin     binary result (registered)
//   res_id      owner of res_bin (registered)
//   busy        high whenever the engine is not idle (combinational)
// -----------------------------------------------------------------------------
module gray_conv_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [0:WIDTH-1] req0_gray,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [0:WIDTH-1] req1_gray,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [0:WIDTH-1] res_bin,
  output logic             res_id,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q,     state_d;
  logic             prio_q,      prio_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [0:WIDTH-1] shift_q,     shift_d;
  logic             acc_q,       acc_d;
  logic             res_valid_q, res_valid_d;
  logic [0:WIDTH-1] res_bin_q,   res_bin_d;
  logic             res_id_q,    res_id_d;

  logic             gnt_any;
  logic             gnt_id;
  logic             conv_bit;

  // ---------------------------------------------------------------------------
  // Arbitration
  // When both requesters are valid, prio selects the winner. When only one is
  // valid, it wins, so the ID is simply req1_valid. The ready outputs are
  // decoded from IDLE only, so a grant can never be issued in CONV or HOLD.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_any    = req0_valid | req1_valid;
    gnt_id     = (req0_valid & req1_valid) ? prio_q : req1_valid;
    req0_ready = (state_q == IDLE) & gnt_any & ~gnt_id;
    req1_ready = (state_q == IDLE) & gnt_any &  gnt_id;
    busy       = (state_q != IDLE);
  end

  // The current Gray bit always sits at shift_q[0]. The word shifts toward
  // the MSB end once per CONV cycle. The accumulator holds the previously
  // produced binary bit, so each result bit is the XOR prefix of the Gray word.
  assign conv_bit = acc_q ^ shift_q[0];

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    res_valid_d = res_valid_q;
    res_bin_d   = res_bin_q;
    res_id_d    = res_id_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d  = CONV;
          prio_d   = ~gnt_id;
          shift_d  = gnt_id ? req1_gray : req0_gray;
          res_id_d = gnt_id;
          acc_d    = 1'b0;
          cnt_d    = '0;
        end
      end

      CONV: begin
        res_bin_d[cnt_q] = conv_bit;
        acc_d            = conv_bit;
        shift_d          = {shift_q[1:WIDTH-1], 1'b0};
        if (cnt_q == LAST_BIT) begin
          state_d     = HOLD;
          res_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        // The result stays frozen until the consumer takes it. Arbitration
        // resumes in the following IDLE cycle, not on this edge.
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      acc_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_bin_q   <= '0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      res_bin_q   <= res_bin_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_bin   = res_bin_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// -----------------------------------------------------------------------------
// tb_gray_conv_scheduler
//
// Drives a WIDTH=4 instance and a WIDTH=8 instance of gray_conv_scheduler.
// The expected binary word is computed as the XOR of the Gray word with all of
// its right shifts. The expected owner comes from a round-robin model that
// holds only the "who goes next" bit.
// -----------------------------------------------------------------------------
module tb_gray_conv_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0 drives the WIDTH=4 instance; index 1 drives the WIDTH=8 instance.
  logic       v0 [2];
  logic       v1 [2];
  logic       rr [2];
  logic [7:0] g0 [2];
  logic [7:0] g1 [2];

  logic       rdy0_4, rdy1_4, rv_4, rid_4, busy_4;
  logic [0:3] rb_4;
  logic       rdy0_8, rdy1_8, rv_8, rid_8, busy_8;
  logic [0:7] rb_8;

  logic       o_rdy0 [2];
  logic       o_rdy1 [2];
  logic       o_rv   [2];
  logic       o_rid  [2];
  logic       o_busy [2];
  logic [7:0] o_rb   [2];

  gray_conv_scheduler #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[0]), .req0_gray(g0[0][3:0]), .req0_ready(rdy0_4),
    .req1_valid(v1[0]), .req1_gray(g1[0][3:0]), .req1_ready(rdy1_4),
    .res_valid(rv_4), .res_ready(rr[0]), .res_bin(rb_4), .res_id(rid_4),
    .busy(busy_4)
  );

  gray_conv_scheduler #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[1]), .req0_gray(g0[1]), .req0_ready(rdy0_8),
    .req1_valid(v1[1]), .req1_gray(g1[1]), .req1_ready(rdy1_8),
    .res_valid(rv_8), .res_ready(rr[1]), .res_bin(rb_8), .res_id(rid_8),
    .busy(busy_8)
  );

  always_comb begin
    o_rdy0[0] = rdy0_4;  o_rdy0[1] = rdy0_8;
    o_rdy1[0] = rdy1_4;  o_rdy1[1] = rdy1_8;
    o_rv[0]   = rv_4;    o_rv[1]   = rv_8;
    o_rid[0]  = rid_4;   o_rid[1]  = rid_8;
    o_busy[0] = busy_4;  o_busy[1] = busy_8;
    o_rb[0]   = {4'h0, rb_4};
    o_rb[1]   = rb_8;
  end

  int total = 0;
  int bad   = 0;
  int prio_m [2];   // model: which requester wins the next tie

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Binary value of a Gray code: XOR of the code with every right shift of it.
  function automatic int gray2bin(input int g, input int w);
    int b = g;
    for (int s = 1; s < w; s++) b ^= (g >> s);
    return b & ((1 << w) - 1);
  endfunction

  // One transaction, started at a negedge with the DUT idle. Both requesters'
  // valids and words are applied. The task checks the grant, the latency, the
  // result, the stability of the result during `stall` cycles of backpressure,
  // and the release. When keep is set, both valids stay high afterwards.
  task automatic xact(input int d, input bit a0, input bit a1, input int ga,
                      input int gb, input int stall, input bit keep);
    int  w = (d != 0) ? 8 : 4;
    int  exp_id;
    int  exp_bin;
    int  n;
    v0[d] = a0; v1[d] = a1; g0[d] = 8'(ga); g1[d] = 8'(gb); rr[d] = 1'b0;
    #1;
    exp_id    = (a0 && a1) ? prio_m[d] : (a1 ? 1 : 0);
    prio_m[d] = (exp_id == 0) ? 1 : 0;
    exp_bin   = gray2bin((exp_id != 0) ? gb : ga, w);
    chk("idle_busy", o_busy[d], 0);
    chk("grant_rdy0", o_rdy0[d], (exp_id == 0));
    chk("grant_rdy1", o_rdy1[d], (exp_id == 1));
    @(negedge clk);                       // the accept edge has passed
    if (!keep) begin
      if (exp_id == 0) v0[d] = 1'b0; else v1[d] = 1'b0;
    end
    chk("conv_busy", o_busy[d], 1);
    chk("conv_rdy0", o_rdy0[d], 0);
    chk("conv_rdy1", o_rdy1[d], 0);
    n = 0;
    while (!o_rv[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, w);
    chk("res_bin", o_rb[d], exp_bin);
    chk("res_id", o_rid[d], exp_id);
    $display("xact dut_w=%0d id=%0d gray=%0h bin=%0h stall=%0d", w, exp_id,
             (exp_id != 0) ? gb : ga, o_rb[d], stall);
    repeat (stall) begin
      @(negedge clk);
      chk("hold_valid", o_rv[d], 1);
      chk("hold_bin", o_rb[d], exp_bin);
      chk("hold_id", o_rid[d], exp_id);
      chk("hold_busy", o_busy[d], 1);
      chk("hold_rdy", {o_rdy0[d], o_rdy1[d]}, 0);
    end
    rr[d] = 1'b1;
    @(negedge clk);
    rr[d] = 1'b0;
    chk("release_valid", o_rv[d], 0);
    chk("release_busy", o_busy[d], 0);
    if (!keep) begin
      v0[d] = 1'b0;
      v1[d] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, id, other;
    for (int d = 0; d < 2; d++) begin
      v0[d] = 1'b0; v1[d] = 1'b0; rr[d] = 1'b0; g0[d] = '0; g1[d] = '0;
      prio_m[d] = 0;
    end

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", o_rv[0], 0);
    chk("rst_bin", o_rb[0], 0);
    chk("rst_id", o_rid[0], 0);
    chk("rst_busy", o_busy[0], 0);
    chk("rst_rdy", {o_rdy0[0], o_rdy1[0]}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single requests
    xact(0, 1, 0, 4'b0110, 0, 0, 0);      // expect bin 0100, id 0
    xact(0, 0, 1, 0, 4'b1000, 0, 0);      // expect bin 1111, id 1

    // Contention straight after reset, then continuous alternation
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    prio_m[0] = 0; prio_m[1] = 0;
    xact(0, 1, 1, 4'b0001, 4'b1100, 0, 1);  // id 0, bin 0001
    xact(0, 1, 1, 4'b0001, 4'b1100, 0, 1);  // id 1, bin 1000
    xact(0, 1, 1, 4'b0001, 4'b1100, 0, 1);  // id 0
    xact(0, 1, 1, 4'b0001, 4'b1100, 0, 0);  // id 1

    // Backpressure: 5 cycles in HOLD
    xact(0, 1, 0, 4'b1011, 0, 5, 0);

    // Reset during the second CONV cycle discards the word
    v0[0] = 1'b1; g0[0] = 8'h5;
    #1;
    chk("pre_rst_grant", o_rdy0[0], 1);
    @(negedge clk);                       // CONV cycle 1
    v0[0] = 1'b0;
    @(negedge clk);                       // CONV cycle 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", o_rv[0], 0);
    chk("midrst_busy", o_busy[0], 0);
    prio_m[0] = 0; prio_m[1] = 0;
    repeat (6) @(negedge clk);
    chk("midrst_no_result", o_rv[0], 0);
    xact(0, 1, 1, 4'b0011, 4'b0101, 1, 0); // req0 must win after reset

    // Sweep all 16 codes with random requesters and random stalls
    for (int g = 0; g < 16; g++) begin
      a0 = int'($urandom_range(0, 1));
      a1 = int'($urandom_range(0, 1));
      if (a0 == 0 && a1 == 0) a0 = 1;
      id    = (a0 != 0 && a1 != 0) ? prio_m[0] : a1;
      other = int'($urandom_range(0, 15));
      if (id == 0) xact(0, a0[0], a1[0], g, other, int'($urandom_range(0, 3)), 0);
      else         xact(0, a0[0], a1[0], other, g, int'($urandom_range(0, 3)), 0);
    end

    // Random sample at WIDTH = 8
    for (int k = 0; k < 12; k++) begin
      a0 = int'($urandom_range(0, 1));
      a1 = int'($urandom_range(0, 1));
      if (a0 == 0 && a1 == 0) a1 = 1;
      xact(1, a0[0], a1[0], int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 3)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
